// File: rtl/result_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_packer_pkg
// Brief    : Shared op-code constants, op-to-chunk-count lookup, packer state
//            encoding and output-word field offsets for result_packer.
// Revision : 1.0 - initial release
// ============================================================================
package result_packer_pkg;

  // Op codes that qualify a result; any other value is unknown
  localparam logic [2:0] c_OP_ADD   = 3'b001;
  localparam logic [2:0] c_OP_MUL   = 3'b010;
  localparam logic [2:0] c_OP_SHIFT = 3'b011;

  // Packer control states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Output word layout, LSB first: payload, idx, sel, last, app
  localparam int unsigned c_OFF_PAYLOAD = 0;

  function automatic int unsigned off_idx(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned off_sel(input int unsigned data_w, input int unsigned idx_w);
    return data_w + idx_w;
  endfunction

  function automatic int unsigned off_last(input int unsigned data_w, input int unsigned idx_w);
    return data_w + idx_w + 1;
  endfunction

  function automatic int unsigned off_app(input int unsigned data_w, input int unsigned idx_w);
    return data_w + idx_w + 2;
  endfunction

  // Words per result for an op code; zero marks an unknown op code
  function automatic int unsigned op_chunks(input logic [7:0] op);
    case (op)
      {5'd0, c_OP_ADD}:   return 2;
      {5'd0, c_OP_MUL}:   return 4;
      {5'd0, c_OP_SHIFT}: return 2;
      default:            return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : result_packer_if
// Brief    : Result capture and output-word handshake bundle for
//            result_packer. The slave modport is the packer's view.
// Revision : 1.0 - initial release
// ============================================================================
interface result_packer_if #(
  parameter int DATA_W     = 40,
  parameter int MAX_CHUNKS = 4,
  parameter int APP_W      = 3,
  parameter int IDX_W      = 3
);
  logic [DATA_W*MAX_CHUNKS-1:0]      result;
  logic [APP_W-1:0]                  app;
  logic                              sel;
  logic                              done;
  logic                              in_ready;
  logic [APP_W+2+IDX_W+DATA_W-1:0]   out_data;
  logic                              out_valid;
  logic                              out_ready;

  modport master (
    output result, app, sel, done, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  result, app, sel, done, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/packer_chunk_mux.sv
`default_nettype none
// ============================================================================
// Module   : packer_chunk_mux
// Brief    : Selects the DATA_W payload for word k of an n-word result,
//            most significant chunk first.
// Revision : 1.0 - initial release
// ============================================================================
module packer_chunk_mux #(
  parameter int DATA_W     = 40,
  parameter int MAX_CHUNKS = 4,
  parameter int IDX_W      = 3
) (
  input  wire logic [DATA_W*MAX_CHUNKS-1:0] data,
  input  wire logic [IDX_W:0]               n,
  input  wire logic [IDX_W-1:0]             k,
  output logic      [DATA_W-1:0]            payload
);
  localparam int POS_W = IDX_W + 1;

  logic [DATA_W-1:0] w_chunk [MAX_CHUNKS];
  logic [POS_W-1:0]  w_pos;

  genvar gi;
  for (gi = 0; gi < MAX_CHUNKS; gi++) begin : g_chunk
    assign w_chunk[gi] = data[gi*DATA_W +: DATA_W];
  end

  // Chunk position counted from the LSB end; wraps out of range when n is 0
  assign w_pos = n - {1'b0, k} - POS_W'(1);

  // Pick the chunk at w_pos, zero when no chunk matches
  always_comb begin
    payload = '0;
    for (int i = 0; i < MAX_CHUNKS; i++) begin
      if (w_pos == POS_W'(i)) payload = w_chunk[i];
    end
  end
endmodule
`default_nettype wire

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// Module   : result_packer
// Brief    : Captures a wide signed result with its op code and streams it as
//            N tagged words {app, last, sel, idx, payload}, MSB chunk first.
//            Optional sticky err output under macro RESULT_PACKER_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module result_packer
  import result_packer_pkg::*;
#(
  parameter int DATA_W     = 40,
  parameter int MAX_CHUNKS = 4,
  parameter int APP_W      = 3,
  parameter int IDX_W      = 3
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  result_packer_if.slave  bus
`ifdef RESULT_PACKER_ERR_EN
  ,
  output logic            err
`endif
);
  localparam int CNT_W = IDX_W + 1;
  localparam int WORD_W = APP_W + 2 + IDX_W + DATA_W;
  localparam int unsigned c_IDX_LSB  = off_idx(DATA_W);
  localparam int unsigned c_SEL_LSB  = off_sel(DATA_W, IDX_W);
  localparam int unsigned c_LAST_LSB = off_last(DATA_W, IDX_W);
  localparam int unsigned c_APP_LSB  = off_app(DATA_W, IDX_W);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [DATA_W*MAX_CHUNKS-1:0]  r_result;
  logic [APP_W-1:0]              r_app;
  logic                          r_sel;
  logic [IDX_W-1:0]              r_k;
  logic [CNT_W-1:0]              r_n;
  logic [CNT_W-1:0]              w_n_in;
  logic                          w_known;
  logic                          w_capture;
  logic                          w_accept;
  logic                          w_last;
  logic [DATA_W-1:0]             w_payload;
  logic [WORD_W-1:0]             w_word;

  assign w_n_in   = CNT_W'(op_chunks(8'(bus.app)));
  assign w_known  = (w_n_in != '0);
  assign w_last   = ({1'b0, r_k} == (r_n - CNT_W'(1)));
  assign w_accept = (r_state == ST_SEND) && bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: capture known ops in IDLE, leave SEND once the last word is taken
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.done && w_known) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.out_ready && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture registers and word counter; inputs are frozen for the whole transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_app    <= '0;
      r_sel    <= 1'b0;
      r_n      <= '0;
      r_k      <= '0;
    end else if (w_capture) begin
      r_result <= bus.result;
      r_app    <= bus.app;
      r_sel    <= bus.sel;
      r_n      <= w_n_in;
      r_k      <= '0;
    end else if (w_accept) begin
      r_k <= w_last ? '0 : r_k + IDX_W'(1);
    end
  end

  packer_chunk_mux #(
    .DATA_W     (DATA_W),
    .MAX_CHUNKS (MAX_CHUNKS),
    .IDX_W      (IDX_W)
  ) u_chunk_mux (
    .data    (r_result),
    .n       (r_n),
    .k       (r_k),
    .payload (w_payload)
  );

  // Assemble the tagged output word from the frozen capture
  always_comb begin
    w_word = '0;
    w_word[c_OFF_PAYLOAD +: DATA_W] = w_payload;
    w_word[c_IDX_LSB +: IDX_W]      = r_k;
    w_word[c_SEL_LSB]               = r_sel;
    w_word[c_LAST_LSB]              = w_last;
    w_word[c_APP_LSB +: APP_W]      = r_app;
  end

  assign bus.out_valid = (r_state == ST_SEND);
  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_data  = (r_state == ST_SEND) ? w_word : '0;

`ifdef RESULT_PACKER_ERR_EN
  logic r_err;

  // Sticky flag: done while busy (overrun) or done with an unknown op code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (bus.done && ((r_state == ST_SEND) || !w_known)) r_err <= 1'b1;
  end

  assign err = r_err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_packer
// Brief    : Self-checking bench for result_packer: directed scenarios plus
//            random traffic against a queue-based word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_packer;
  localparam int DATA_W     = 40;
  localparam int MAX_CHUNKS = 4;
  localparam int APP_W      = 3;
  localparam int IDX_W      = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_packer_if #(
    .DATA_W(DATA_W), .MAX_CHUNKS(MAX_CHUNKS), .APP_W(APP_W), .IDX_W(IDX_W)
  ) bus ();

`ifdef RESULT_PACKER_ERR_EN
  logic err;
`endif

  result_packer #(
    .DATA_W(DATA_W), .MAX_CHUNKS(MAX_CHUNKS), .APP_W(APP_W), .IDX_W(IDX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RESULT_PACKER_ERR_EN
    ,
    .err   (err)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [63:0] acc_log[$];
  int acc_cnt = 0;
  logic err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_n(input logic [2:0] a);
    case (a)
      3'd1:    return 2;
      3'd2:    return 4;
      3'd3:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_word(input logic [2:0] a, input logic last,
                                           input logic s, input logic [2:0] idx,
                                           input logic [39:0] payload);
    return 64'({a, last, s, idx, payload});
  endfunction

  function automatic logic [159:0] rand_result();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: queue of words still owed to the sink
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      if (bus.done && (q.size() != 0 || ref_n(bus.app) == 0)) err_exp = 1'b1;
      if (q.size() != 0) begin
        if (bus.out_ready) void'(q.pop_front());
      end else if (bus.done && ref_n(bus.app) != 0) begin
        int n;
        n = ref_n(bus.app);
        for (int k = 0; k < n; k++) begin
          logic [39:0] pl;
          pl = 40'(bus.result >> ((n - 1 - k) * DATA_W));
          q.push_back(ref_word(bus.app, (k == n - 1), bus.sel, 3'(k), pl));
        end
      end
    end
  end

  // Monitor on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
      if (q.size() != 0) chk("out_data", 64'(bus.out_data), q[0]);
`ifdef RESULT_PACKER_ERR_EN
      chk("err", 64'(err), 64'(err_exp));
`endif
      if (bus.out_valid && bus.out_ready) begin
        acc_log.push_back(64'(bus.out_data));
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] a, input logic [159:0] r, input logic s);
    bus.app    = a;
    bus.result = r;
    bus.sel    = s;
    bus.done   = 1'b1;
    tick();
    bus.done   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, output int cycles);
    cycles = 0;
    while (q.size() != 0 && cycles < 200) begin
      tick();
      cycles++;
    end
    chk({tag, "_drain"}, 64'(q.size() == 0), 64'd1);
  endtask

  task automatic wait_acc(input string tag, input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, 64'(acc_cnt >= target), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    bus.done = 1'b0; bus.app = '0; bus.result = '0; bus.sel = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // ADD with known result
    acc_log.delete();
    send(3'b001, {80'h0, 80'h0123456789ABCDEF0123}, 1'b0);
    wait_drain("add", cyc);
    chk("add_count", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() == 2) begin
      chk("add_w0", acc_log[0], 64'({3'b001, 1'b0, 1'b0, 3'd0, 40'h0123456789}));
      chk("add_w1", acc_log[1], 64'({3'b001, 1'b1, 1'b0, 3'd1, 40'hABCDEF0123}));
    end
    tick();

    // MUL with sel=1, inputs disturbed while in flight
    acc_log.delete();
    send(3'b010, rand_result(), 1'b1);
    bus.app = 3'b000; bus.result = rand_result(); bus.sel = 1'b0;
    wait_drain("mul", cyc);
    chk("mul_cycles", 64'(cyc), 64'd4);
    chk("mul_count", 64'(acc_log.size()), 64'd4);
    tick();

    // MUL with 5-cycle stall at word 2
    base = acc_cnt;
    send(3'b010, rand_result(), 1'b0);
    wait_acc("stall", base + 2);
    bus.out_ready = 1'b0;
    repeat (5) tick();
    chk("stall_held", 64'(acc_cnt - base), 64'd2);
    bus.out_ready = 1'b1;
    wait_drain("stall", cyc);
    chk("stall_count", 64'(acc_cnt - base), 64'd4);
    tick();

    // done during SEND and done with unknown op
    base = acc_cnt;
    send(3'b001, rand_result(), 1'b1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_drain("ovr", cyc);
    tick();
    bus.app = 3'b101; bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    repeat (3) tick();
    chk("ovr_words", 64'(acc_cnt - base), 64'd2);
    chk("unk_idle", 64'(bus.out_valid), 64'd0);
`ifdef RESULT_PACKER_ERR_EN
    chk("err_set", 64'(err), 64'd1);
`endif

    // Reset in the middle of a MUL transfer
    base = acc_cnt;
    send(3'b010, rand_result(), 1'b0);
    wait_acc("rstmid", base + 2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 64'(bus.out_valid), 64'd0);
    chk("rstmid_data", 64'(bus.out_data), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rstrel_in_ready", 64'(bus.in_ready), 64'd1);
    acc_log.delete();
    send(3'b001, rand_result(), 1'b0);
    wait_drain("rstadd", cyc);
    chk("rstadd_count", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() == 2) chk("rstadd_idx0", 64'(acc_log[0][42:40]), 64'd0);
    tick();

    // done held high with SHIFT: back-to-back 2-word transfers
    acc_log.delete();
    bus.app = 3'b011; bus.result = rand_result(); bus.sel = 1'b1; bus.done = 1'b1;
    repeat (12) tick();
    bus.done = 1'b0;
    wait_drain("shift", cyc);
    chk("shift_even", 64'(acc_log.size() % 2), 64'd0);
    chk("shift_xfers", 64'(acc_log.size()), 64'd8);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.app       = 3'($urandom_range(0, 7));
      bus.result    = rand_result();
      bus.sel       = 1'($urandom_range(0, 1));
      bus.done      = ($urandom_range(0, 2) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.done = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("rand", cyc);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
